// File: rtl/branch_pkg.sv
// Shared branch-op encodings and default widths for the branch resolve path.
package branch_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PC_W  = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'b000,
    BR_BNE    = 3'b001,
    BR_BLTZ   = 3'b010,
    BR_BGEZ   = 3'b011,
    BR_BLEZ   = 3'b100,
    BR_BGTZ   = 3'b101,
    BR_ALWAYS = 3'b110,
    BR_NEVER  = 3'b111
  } branch_op_e;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Purely combinational branch condition evaluation: zero latency, no flow control.
// Zero-relative ops treat op1 as two's complement; op2 only matters for beq/bne.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       branch_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             taken
);

  logic neg;
  logic zero;

  assign neg  = op1[WIDTH-1];
  assign zero = (op1 == '0);

  always_comb begin
    taken = 1'b0;
    case (branch_op_e'(branch_op))
      BR_BEQ:    taken = (op1 == op2);
      BR_BNE:    taken = (op1 != op2);
      BR_BLTZ:   taken = neg;
      BR_BGEZ:   taken = ~neg;
      BR_BLEZ:   taken = neg | zero;
      BR_BGTZ:   taken = ~neg & ~zero;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: one registered cycle from accept to out_valid.
// stall holds the output stage and refuses input; flush kills in-flight and incoming.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       branch_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [PC_W-1:0]  pc_plus4,
  input  logic [PC_W-1:0]  target,
  input  logic             pred_taken,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [PC_W-1:0]  out_redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic             taken;
  logic             wrong;
  logic             accept;
  logic             valid_q;
  logic             taken_q;
  logic             mis_q;
  logic [PC_W-1:0]  redir_q;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mis_cnt_q;

  branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .branch_op (branch_op),
    .op1       (op1),
    .op2       (op2),
    .taken     (taken)
  );

  assign wrong  = taken ^ pred_taken;
  assign accept = in_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      mis_q     <= 1'b0;
      redir_q   <= '0;
      br_q      <= '0;
      mis_cnt_q <= '0;
    end else begin
      // flush only clears the valid bit; payload fields keep their last value
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q <= in_valid;
        if (in_valid) begin
          taken_q <= taken;
          mis_q   <= wrong;
          redir_q <= taken ? target : pc_plus4;
        end
      end

      if (cnt_clr) begin
        br_q <= '0;
      end else if (accept && (br_q != '1)) begin
        br_q <= br_q + CNT_W'(1);
      end

      if (cnt_clr) begin
        mis_cnt_q <= '0;
      end else if (accept && wrong && (mis_cnt_q != '1)) begin
        mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready        = ~stall;
  assign out_valid       = valid_q;
  assign out_taken       = taken_q;
  assign out_mispredict  = mis_q & valid_q;
  assign out_redirect_pc = redir_q;
  assign br_count        = br_q;
  assign mispred_count   = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit against a spec-level reference model.
module tb_branch_resolve_unit;

  localparam int WIDTH = 32;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       branch_op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  target;
  logic             pred_taken;
  logic             stall;
  logic             flush;
  logic             cnt_clr;
  logic             out_valid;
  logic             out_taken;
  logic             out_mispredict;
  logic [PC_W-1:0]  out_redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(WIDTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .branch_op       (branch_op),
    .op1             (op1),
    .op2             (op2),
    .pc_plus4        (pc_plus4),
    .target          (target),
    .pred_taken      (pred_taken),
    .stall           (stall),
    .flush           (flush),
    .cnt_clr         (cnt_clr),
    .out_valid       (out_valid),
    .out_taken       (out_taken),
    .out_mispredict  (out_mispredict),
    .out_redirect_pc (out_redirect_pc),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  typedef struct packed {
    logic            taken;
    logic            mis;
    logic [PC_W-1:0] redir;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;
  int   m_br     = 0;
  int   m_mis    = 0;
  bit   held     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    sa = $signed(a);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa < 0;
      3'd3:    return sa >= 0;
      3'd4:    return sa <= 0;
      3'd5:    return sa > 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: inputs are stable at the edge because they change #1 later.
  initial forever begin
    bit acc;
    bit t;
    exp_t e;
    @(posedge clk);
    acc = reset && in_valid && !stall && !flush;
    t   = ref_taken(branch_op, op1, op2);
    if (!reset) begin
      m_br  = 0;
      m_mis = 0;
      held  = 1'b0;
      exp_q.delete();
    end else begin
      held = stall && !flush;
      if (cnt_clr) begin
        m_br  = 0;
        m_mis = 0;
      end else if (acc) begin
        if (m_br < SAT) m_br++;
        if ((t != pred_taken) && (m_mis < SAT)) m_mis++;
      end
      if (acc) begin
        e.taken = t;
        e.mis   = t ^ pred_taken;
        e.redir = t ? target : pc_plus4;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: a fresh result is one not merely held over by stall.
  initial begin
    @(posedge clk);
    forever begin
      bit fresh;
      exp_t e;
      @(negedge clk);
      fresh = out_valid && !held;
      check("in_ready", in_ready, !stall);
      check("br_count", br_count, m_br);
      check("mispred_count", mispred_count, m_mis);
      if (!out_valid) check("mispredict_gated", out_mispredict, 0);
      check("latency", fresh, exp_q.size() != 0);
      if (fresh && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        check("out_taken", out_taken, e.taken);
        check("out_mispredict", out_mispredict, e.mis);
        check("out_redirect_pc", out_redirect_pc, e.redir);
      end else if (out_valid && held) begin
        check("held_taken", out_taken, last_exp.taken);
        check("held_mispredict", out_mispredict, last_exp.mis);
        check("held_redirect", out_redirect_pc, last_exp.redir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc4, input logic [31:0] tgt, input logic pred);
    in_valid   = 1'b1;
    branch_op  = op;
    op1        = a;
    op2        = b;
    pc_plus4   = pc4;
    target     = tgt;
    pred_taken = pred;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc4, input logic [31:0] tgt, input logic pred);
    drive(op, a, b, pc4, tgt, pred);
    step();
    in_valid = 1'b0;
  endtask

  int sg_op[7]  = '{2, 3, 4, 5, 4, 5, 3};
  int sg_a[7]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
  int sg_exp[7] = '{1, 0, 1, 0, 1, 0, 1};

  initial begin
    logic [CNT_W-1:0] br_save;
    logic [31:0] a;

    reset = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drive(3'd6, 32'd1, 32'd1, 32'h100, 32'h200, 1'b0);
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_br_count", br_count, 0);
    check("rst_mispred_count", mispred_count, 0);
    check("rst_redirect", out_redirect_pc, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      issue(3'(sg_op[i]), sg_a[i], $urandom, 32'h1004, 32'h2000, $urandom_range(0, 1));
      check("signed_cmp", out_taken, sg_exp[i]);
    end

    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    issue(3'd0, 32'd5, 32'd5, 32'h400008, 32'h400100, 1'b0);
    check("beq_taken", out_taken, 1);
    check("beq_mispredict", out_mispredict, 1);
    check("beq_redirect", out_redirect_pc, 32'h400100);
    check("beq_mispred_count", mispred_count, 1);
    issue(3'd0, 32'd5, 32'd5, 32'h400008, 32'h400100, 1'b1);
    check("beq_pred_ok", out_mispredict, 0);
    check("beq_mispred_hold", mispred_count, 1);

    issue(3'd6, 32'd0, 32'd0, 32'h3004, 32'h3800, 1'b1);
    br_save = br_count;
    drive(3'd1, 32'd1, 32'd2, 32'h5004, 32'h5800, 1'b0);
    stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_redirect", out_redirect_pc, 32'h3800);
      check("stall_br_count", br_count, br_save);
    end
    flush = 1'b1;
    step();
    check("flush_out_valid", out_valid, 0);
    check("flush_br_count", br_count, br_save);
    stall = 1'b0;
    step();
    check("flush_in_bne", br_count, br_save);
    flush = 1'b0; in_valid = 1'b0;
    step();

    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    drive(3'd6, 32'd0, 32'd0, 32'h10, 32'h20, 1'b0);
    repeat (20) step();
    check("sat_br_count", br_count, SAT);
    check("sat_mispred_count", mispred_count, SAT);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; in_valid = 1'b0;
    check("clr_br_count", br_count, 0);
    check("clr_mispred_count", mispred_count, 0);

    issue(3'd7, 32'd9, 32'd9, 32'h7004, 32'h7800, 1'b1);
    check("never_taken", out_taken, 0);
    check("never_mispredict", out_mispredict, 1);
    check("never_redirect", out_redirect_pc, 32'h7004);
    issue(3'd6, 32'd9, 32'd9, 32'h8004, 32'h8800, 1'b1);
    check("always_taken", out_taken, 1);
    check("always_redirect", out_redirect_pc, 32'h8800);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'd0;
        1:       a = 32'hFFFFFFFF;
        2:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      drive(3'($urandom_range(0, 7)), a, ($urandom_range(0, 1) != 0) ? a : $urandom,
            $urandom, $urandom, $urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 8) == 0);
      cnt_clr  = ($urandom_range(0, 24) == 0);
      reset    = ($urandom_range(0, 96) != 0);
      step();
    end

    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; reset = 1'b1;
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
